prirv32_mem_arbiter: RTL
========================

Name: priRV32_mem_arbiter

Overview:
- Shares one synchronous single-port SRAM between the IFU instruction fetch port and the EXU load/store port.
- Arbitration: fixed priority to data, with a starvation guard for fetch.
- Handshake: req/gnt on the request side, a registered response one cycle later, routed back to the requester that issued the access.
- Placement: sits between the core's fetch/data address buses and a unified memory, replacing the separate itcm/data ports.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_MAX, 4, consecutive data grants allowed while fetch is waiting; range 1..15.

Ports:
- clk_i  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- if_req_i  in  1  fetch request.
- if_addr_i  in  ADDR_W  fetch address.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch read data valid.
- if_rdata_o  out  DATA_W  fetch read data.
- d_req_i  in  1  data request.
- d_we_i  in  1  1 = write, 0 = read.
- d_be_i  in  DATA_W/8  byte enables for writes.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  write data.
- d_gnt_o  out  1  data request accepted this cycle.
- d_rvalid_o  out  1  data response (read data or write ack).
- d_rdata_o  out  DATA_W  data read data; 0 for write acks.
- mem_en_o  out  1  SRAM access enable.
- mem_we_o  out  1  SRAM write enable.
- mem_be_o  out  DATA_W/8  SRAM byte enables.
- mem_addr_o  out  ADDR_W  SRAM address; word index taken by the memory from bits [ADDR_W-1:2].
- mem_wdata_o  out  DATA_W  SRAM write data.
- mem_rdata_i  in  DATA_W  SRAM read data, valid the cycle after a read enable.

Behaviour:
- Reset: rst_n (asynchronous, active-low), clock clk_i.
  - All registered state clears on reset: resp_state = IDLE, starve_cnt = 0.
  - While rst_n = 0: if_gnt_o, d_gnt_o, mem_en_o, if_rvalid_o and d_rvalid_o are all 0; rdata outputs are 0.
- Grant is combinational from the requests plus the registered starve_cnt. At most one grant per cycle. A transfer occurs on req & gnt.
- Priority:
  - Data wins when both requests are high.
  - Exception: when starve_cnt == STARVE_MAX and if_req_i = 1, fetch is granted instead.
  - A lone requester is always granted the same cycle; no bubbles.
- starve_cnt:
  - Increments on each data grant while if_req_i = 1.
  - Clears on a fetch grant or whenever if_req_i = 0.
  - Saturates at STARVE_MAX.
- Memory drive:
  - mem_en_o = if_gnt_o | d_gnt_o.
  - Address, write data, byte enables and we come from the granted port.
  - Fetch accesses drive mem_we_o = 0 and mem_be_o = all ones.
  - When no grant is active, mem_we_o = 0 and the other mem outputs are don't-care.
- Response FSM, registered, states IDLE / RESP_IF / RESP_DR / RESP_DW:
  - Next state = RESP_IF on a fetch grant, RESP_DR on a data read grant, RESP_DW on a data write grant, else IDLE.
  - In RESP_IF: if_rvalid_o = 1 and if_rdata_o = mem_rdata_i.
  - In RESP_DR: d_rvalid_o = 1 and d_rdata_o = mem_rdata_i.
  - In RESP_DW: d_rvalid_o = 1 and d_rdata_o = 0.
  - In IDLE: both rvalid outputs are 0.
  - The FSM transitions every cycle, so grants can be back-to-back. Response latency is exactly 1 cycle after the grant and is never stalled; requesters must always accept responses.
- Requests are not held internally: a requester that is not granted must keep req, address and data stable until granted.
- Reset mid-operation: a response pending at reset assertion is dropped. No rvalid appears after rst_n deasserts until a new grant occurs.
- Misaligned addresses are not checked; the low 2 address bits are passed through unchanged.

Decomposition:
- Shared package priRV32_pkg:
  - Response-state encoding constants: RESP_IDLE = 2'd0, RESP_IF = 2'd1, RESP_DR = 2'd2, RESP_DW = 2'd3.
  - Default widths ADDR_W / DATA_W.
- One natural sub-module, priRV32_arb_prio: 2-input priority selector containing starve_cnt and the grant logic. It outputs if_gnt / d_gnt.
- The response FSM and the memory mux stay in the top of this block.

Test Plan:
- Fetch-only read: if_req_i = 1 with if_addr_i = 0x100 and memory word 0x00000013 at that address.
  - -> if_gnt_o = 1 in cycle 0; mem_en_o = 1, mem_addr_o = 0x100.
  - -> if_rvalid_o = 1 with if_rdata_o = 0x00000013 in cycle 1; d_rvalid_o = 0.
- Simultaneous requests: if_req_i = 1 (0x104) and d_req_i = 1 as a read of 0x2000 in the same cycle.
  - -> d_gnt_o = 1 and if_gnt_o = 0.
  - -> next cycle: d_rvalid_o = 1, and if_gnt_o = 1 for 0x104.
- Starvation guard, STARVE_MAX = 4: d_req_i and if_req_i both held high continuously.
  - -> data is granted 4 cycles in a row.
  - -> fetch is granted in the 5th cycle, then starve_cnt = 0 and the data-first pattern repeats.
- Write ack: d_we_i = 1, d_be_i = 4'b0011, d_addr_i = 0x2004, d_wdata_i = 0xDEADBEEF.
  - -> mem_we_o = 1, mem_be_o = 0011 in the grant cycle.
  - -> next cycle d_rvalid_o = 1 with d_rdata_o = 0.
  - -> a subsequent read of 0x2004 returns 0x????BEEF, i.e. only the low bytes updated.
- Back-to-back: alternating data read / fetch grants over 6 cycles.
  - -> each response appears exactly 1 cycle after its grant, routed to the correct port.
  - -> the response valid outputs show no bubbles and no cross-routing.
- Reset mid-read: grant a fetch, then assert rst_n = 0 before the response cycle.
  - -> if_rvalid_o = 0 during reset and after release.
  - -> all grants are 0 while reset is asserted.

Source files
------------

// File: rtl/prirv32_pkg.sv
// priRV32 shared definitions for the unified-memory arbiter.
// Response-state encoding and default bus widths.
package prirv32_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Wide enough for any STARVE_MAX in 1..15.
    localparam int CNT_W = 4;

    localparam logic [1:0] RESP_IDLE = 2'd0;
    localparam logic [1:0] RESP_IF   = 2'd1;
    localparam logic [1:0] RESP_DR   = 2'd2;
    localparam logic [1:0] RESP_DW   = 2'd3;

endpackage

// File: rtl/prirv32_arb_prio.sv
// priRV32 fetch/data priority selector.
// Data first; fetch forced through after STARVE_MAX data grants.
module prirv32_arb_prio
    import prirv32_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic if_req_i,
    input  logic d_req_i,
    output logic if_gnt_o,
    output logic d_gnt_o
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_nxt;
    logic             starved;

    assign starved = if_req_i & (starve_cnt == MAX_C);

    // Grant selection; nothing is granted while reset is asserted.
    always_comb begin
        if_gnt_o = 1'b0;
        d_gnt_o  = 1'b0;
        if (!rst_n) begin
            if_gnt_o = 1'b0;
        end else if (starved) begin
            if_gnt_o = 1'b1;
        end else if (d_req_i) begin
            d_gnt_o = 1'b1;
        end else if (if_req_i) begin
            if_gnt_o = 1'b1;
        end
    end

    // Count data grants that overtook a waiting fetch.
    always_comb begin
        starve_nxt = starve_cnt;
        if (!if_req_i || if_gnt_o) begin
            starve_nxt = '0;
        end else if (d_gnt_o && (starve_cnt != MAX_C)) begin
            starve_nxt = starve_cnt + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_nxt;
        end
    end

endmodule

// File: rtl/prirv32_mem_arbiter.sv
// priRV32 arbiter sharing one single-port SRAM between IFU and EXU.
// Combinational grant, one-cycle registered response routing.
module prirv32_mem_arbiter
    import prirv32_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    logic       if_gnt;
    logic       d_gnt;
    logic [1:0] resp_state;
    logic [1:0] resp_nxt;

    prirv32_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .if_req_i(if_req_i),
        .d_req_i (d_req_i),
        .if_gnt_o(if_gnt),
        .d_gnt_o (d_gnt)
    );

    assign if_gnt_o = if_gnt;
    assign d_gnt_o  = d_gnt;
    assign mem_en_o = if_gnt | d_gnt;

    // Steer the granted port onto the SRAM bus.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = d_be_i;
        mem_addr_o  = d_addr_i;
        mem_wdata_o = d_wdata_i;
        if (if_gnt) begin
            mem_be_o   = '1;
            mem_addr_o = if_addr_i;
        end else if (d_gnt) begin
            mem_we_o = d_we_i;
        end
    end

    // Remember which requester owns next cycle's response.
    always_comb begin
        resp_nxt = RESP_IDLE;
        unique case (1'b1)
            if_gnt:           resp_nxt = RESP_IF;
            d_gnt && !d_we_i: resp_nxt = RESP_DR;
            d_gnt && d_we_i:  resp_nxt = RESP_DW;
            default:          resp_nxt = RESP_IDLE;
        endcase
    end

    // Response state register; a pending response is lost on reset.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            resp_state <= RESP_IDLE;
        end else begin
            resp_state <= resp_nxt;
        end
    end

    // Route SRAM read data to the owner; write acks carry zero.
    always_comb begin
        if_rvalid_o = (resp_state == RESP_IF);
        d_rvalid_o  = (resp_state == RESP_DR) |
                      (resp_state == RESP_DW);
        if_rdata_o  = '0;
        d_rdata_o   = '0;
        if (resp_state == RESP_IF) begin
            if_rdata_o = mem_rdata_i;
        end
        if (resp_state == RESP_DR) begin
            d_rdata_o = mem_rdata_i;
        end
    end

endmodule
